booth_mult_scheduler: RTL and testbench

//  Round-robin scheduler sharing one fixed-latency 16x16 Booth multiplier among NREQ requesters.

---
 rtl/booth_mult_scheduler.sv | 143 ++++++++++++++
 tb/tb_booth_mult_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler that shares one fixed-latency 16x16 multiplier among NREQ requesters,
// tagging each issued op with its requester ID and returning products in issue order.
module booth_mult_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic                 halted,
    output logic                 mul_en,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_prod,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_prod,
    output logic [2:0]           inflight,
    output logic [15:0]          ops_done
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] scan_id;
    logic           grant_any;
    logic           handshake;
    logic [IDW-1:0] issue_id;
    logic [LAT-1:0] tag_v;
    logic [IDW-1:0] tag_id [LAT];
    logic [15:0]    a_arr  [NREQ];
    logic [15:0]    b_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[16*gi+15:16*gi];
            assign b_arr[gi] = req_b[16*gi+15:16*gi];
        end
    endgenerate

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_id = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!grant_any && req_valid[scan_id]) begin
                grant_any = 1'b1;
                grant_id  = scan_id;
            end
        end
        if (!rst && state == RUN && grant_any)
            req_ready[grant_id] = 1'b1;
    end

    assign handshake = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            halted     <= 1'b0;
            rr_ptr     <= '0;
            mul_en     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            issue_id   <= '0;
            tag_v      <= '0;
            for (int unsigned k = 0; k < LAT; k++)
                tag_id[k] <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_prod  <= '0;
            inflight   <= '0;
            ops_done   <= '0;
        end else begin
            mul_en <= handshake;
            if (handshake) begin
                mul_a    <= a_arr[grant_id];
                mul_b    <= b_arr[grant_id];
                issue_id <= grant_id;
                rr_ptr   <= (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
            end

            tag_v[0]  <= mul_en;
            tag_id[0] <= issue_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            resp_valid <= tag_v[LAT-1];
            if (tag_v[LAT-1]) begin
                resp_id   <= tag_id[LAT-1];
                resp_prod <= mul_prod;
            end

            if (handshake && !resp_valid)
                inflight <= inflight + 3'd1;
            else if (!handshake && resp_valid)
                inflight <= inflight - 3'd1;

            if (resp_valid)
                ops_done <= ops_done + 16'd1;

            case (state)
                RUN: begin
                    if (hold) state <= DRAIN;
                    halted <= 1'b0;
                end
                DRAIN: begin
                    if (!hold) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end else if (inflight == '0 && tag_v == '0) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (!hold) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Bench for booth_mult_scheduler: table-driven single ops, hand sequences for hold/reset/wrap,
// and a cycle-by-cycle scoreboard model running alongside random traffic.
module tb_booth_mult_scheduler;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [16*NREQ-1:0]  req_a = '0;
    logic [16*NREQ-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic                hold = 1'b0;
    logic                halted;
    logic                mul_en;
    logic [15:0]         mul_a, mul_b;
    logic [31:0]         mul_prod;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_prod;
    logic [2:0]          inflight;
    logic [15:0]         ops_done;

    int errors = 0;
    int checks = 0;

    booth_mult_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .hold(hold), .halted(halted), .mul_en(mul_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod), .resp_valid(resp_valid),
        .resp_id(resp_id), .resp_prod(resp_prod), .inflight(inflight), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // External multiplier stand-in: product appears LAT cycles after its operands.
    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_prod = mpipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // ---------------- scoreboard model ----------------
    typedef struct { int due; int id; logic [31:0] prod; } exp_t;
    exp_t q[$];
    exp_t ent;
    int  cyc = 0;
    int  m_state = 0;          // 0 running, 1 draining, 2 halted
    int  m_ptr = 0;
    int  m_inflight = 0;
    int  m_ops = 0;
    int  m_pend = 0;
    logic [15:0] m_a = '0, m_b = '0;
    int  m_rid = 0;
    logic [31:0] m_rprod = '0;
    int  eg, jj, rv, nxt_state;
    logic [NREQ-1:0] exp_ready;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_inflight = 0; m_ops = 0; m_pend = 0;
            m_a = '0; m_b = '0; m_rid = 0; m_rprod = '0;
            q.delete();
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_mul_en", 32'(mul_en), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_inflight", 32'(inflight), 0);
            chk("rst_ops_done", 32'(ops_done), 0);
            chk("rst_halted", 32'(halted), 0);
        end else begin
            eg = -1;
            if (m_state == 0)
                for (int k = 0; k < NREQ; k++) begin
                    jj = (m_ptr + k) % NREQ;
                    if (eg < 0 && req_valid[jj]) eg = jj;
                end
            exp_ready = '0;
            if (eg >= 0) exp_ready[eg] = 1'b1;
            rv = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
            if (rv == 1) begin
                m_rid = q[0].id;
                m_rprod = q[0].prod;
                void'(q.pop_front());
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("halted", 32'(halted), (m_state == 2) ? 1 : 0);
            chk("inflight", 32'(inflight), m_inflight);
            chk("ops_done", 32'(ops_done), m_ops & 16'hFFFF);
            chk("mul_en", 32'(mul_en), m_pend);
            chk("mul_a", 32'(mul_a), 32'(m_a));
            chk("mul_b", 32'(mul_b), 32'(m_b));
            chk("resp_valid", 32'(resp_valid), rv);
            chk("resp_id", 32'(resp_id), m_rid);
            chk("resp_prod", resp_prod, m_rprod);

            nxt_state = m_state;
            case (m_state)
                0: if (hold) nxt_state = 1;
                1: if (!hold) nxt_state = 0; else if (m_inflight == 0) nxt_state = 2;
                default: if (!hold) nxt_state = 0;
            endcase
            if (eg >= 0) begin
                m_a = req_a[16*eg +: 16];
                m_b = req_b[16*eg +: 16];
                ent.due = cyc + LAT + 2;
                ent.id = eg;
                ent.prod = ref_mul(m_a, m_b);
                q.push_back(ent);
                m_ptr = (eg + 1) % NREQ;
                m_pend = 1;
            end else begin
                m_pend = 0;
            end
            m_inflight = m_inflight + ((eg >= 0) ? 1 : 0) - rv;
            m_ops = (m_ops + rv) & 16'hFFFF;
            m_state = nxt_state;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct { int r; logic [15:0] a; logic [15:0] b; logic [31:0] p; } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input int r, input logic [15:0] a, input logic [15:0] b,
                           output int id, output logic [31:0] p, output int lat);
        bit got;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_a[16*r +: 16] = a;
        req_b[16*r +: 16] = b;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1;
        end
        chk("vec_grant_seen", 32'(got), 1);
        @(posedge clk); #1;
        req_valid = '0;
        lat = -1; id = -1; p = 'x;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k - 1;
                id = resp_id;
                p = resp_prod;
            end
        end
    endtask

    int id_o, lat_o, n, nresp, cycles;
    logic [31:0] p_o;
    logic [NREQ-1:0] grants[5];
    int rids[$];
    int rcyc[$];
    bit seen;

    initial begin
        vecs[0] = '{0, 16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{2, 16'hFFFF, 16'h0002, 32'hFFFFFFFE};
        vecs[2] = '{2, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[3] = '{1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[4] = '{3, 16'h0000, 16'h1234, 32'h00000000};
        vecs[5] = '{1, 16'h8000, 16'hFFFF, 32'h00008000};
        vecs[6] = '{3, 16'h0100, 16'hFF00, 32'hFFFF0000};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Round-robin with every requester valid, pointer starting at 0
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
        end
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i < 5) grants[i] = req_ready;
            if (resp_valid) begin rids.push_back(resp_id); rcyc.push_back(i); end
            @(posedge clk); #1;
            if (i == 4) req_valid = '0;
        end
        for (int i = 0; i < 5; i++) chk("rr_grant", 32'(grants[i]), 32'(1 << (i % NREQ)));
        chk("rr_resp_count", rids.size(), 5);
        for (int i = 0; i < rids.size() && i < 5; i++) begin
            chk("rr_resp_id", rids[i], i % NREQ);
            if (i > 0) chk("rr_resp_back2back", rcyc[i] - rcyc[i-1], 1);
        end

        // Table-driven single ops
        foreach (vecs[i]) begin
            run_vec(vecs[i].r, vecs[i].a, vecs[i].b, id_o, p_o, lat_o);
            chk("vec_latency", lat_o, LAT + 1);
            chk("vec_id", id_o, vecs[i].r);
            chk("vec_prod", p_o, vecs[i].p);
        end

        // hold asserted while a second op is being accepted
        @(posedge clk); #1 req_valid = '1;
        @(posedge clk); #1 hold = 1'b1;
        @(posedge clk); #1 req_valid = 4'b0100;
        nresp = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            chk("drain_no_ready", 32'(req_ready), 0);
            if (resp_valid) nresp++;
            if (halted) begin
                seen = 1;
                chk("halt_inflight", 32'(inflight), 0);
            end
        end
        chk("halt_reached", 32'(seen), 1);
        chk("drain_resp_count", nresp, 2);
        @(posedge clk); #1 hold = 1'b0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[2]) seen = 1;
        end
        chk("resume_grant", 32'(seen), 1);
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);

        // Reset with two ops in flight
        #1 req_valid = '1;
        @(posedge clk); #1;
        @(posedge clk); #1 req_valid = '0;
        #1 rst = 1'b1;
        #1;
        chk("rstmid_inflight", 32'(inflight), 0);
        chk("rstmid_mul_en", 32'(mul_en), 0);
        chk("rstmid_mul_a", 32'(mul_a), 0);
        chk("rstmid_resp_prod", resp_prod, 0);
        chk("rstmid_ops_done", 32'(ops_done), 0);
        @(posedge clk); #2 rst = 1'b0;
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("rstmid_no_resp", nresp, 0);
        run_vec(1, 16'h0003, 16'h0005, id_o, p_o, lat_o);
        chk("post_rst_id", id_o, 1);
        chk("post_rst_prod", p_o, 32'h0000000F);

        // ops_done wrap: fresh reset, then 65535 random ops, then one more
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1 req_valid = '1;
        n = 0; cycles = 0;
        while (n < 65535 && cycles < 70000) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[16*i +: 16] = 16'($urandom);
                req_b[16*i +: 16] = 16'($urandom);
            end
            @(negedge clk);
            if (|(req_valid & req_ready)) n++;
            cycles++;
            @(posedge clk); #1;
            if (n == 65535) req_valid = '0;
        end
        req_valid = '0;
        chk("wrap_issue_count", n, 65535);
        repeat (LAT + 4) @(negedge clk);
        chk("wrap_preload", 32'(ops_done), 32'h0000FFFF);
        run_vec(0, 16'hFFFF, 16'hFFFF, id_o, p_o, lat_o);
        chk("wrap_prod", p_o, 32'h00000001);
        @(negedge clk);
        chk("wrap_zero", 32'(ops_done), 32'h00000000);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
